// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences the shared mymul/div units for EX-stage mult/div
// requests and holds the pipeline until the 64-bit result is captured.
module muldiv_ctrl #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       op_i,
  input  logic [31:0]      src1_i,
  input  logic [31:0]      src2_i,
  input  logic             ex_hold_i,
  input  logic             flush_i,
  output logic             stallreq_o,
  output logic [31:0]      hi_o,
  output logic [31:0]      lo_o,
  output logic             res_valid_o,
  output logic             mul_start_o,
  output logic             mul_signed_o,
  output logic             mul_annul_o,
  output logic [31:0]      mul_op1_o,
  output logic [31:0]      mul_op2_o,
  input  logic             mul_ready_i,
  input  logic [63:0]      mul_result_i,
  output logic             div_start_o,
  output logic             div_signed_o,
  output logic             div_annul_o,
  output logic [31:0]      div_op1_o,
  output logic [31:0]      div_op2_o,
  input  logic             div_ready_i,
  input  logic [63:0]      div_result_i,
  output logic [CNT_W-1:0] busy_cnt_o
);

  localparam int unsigned W = 32;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     op1_q, op2_q, hi_q, lo_q;
  logic             sgn_q;
  logic [CNT_W-1:0] cnt_q;
  logic             req_div, req_sgn, accept, capture;
  logic [2*W-1:0]   result;

  // Priority decode of the one-hot request: div > divu > mult > multu
  assign req_div = op_i[0] | op_i[1];
  assign req_sgn = op_i[0] | (~op_i[1] & op_i[2]);
  assign result  = (state_q == DIV) ? div_result_i : mul_result_i;

  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign busy_cnt_o = cnt_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and unit handshake; reset forces every strobe low
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    capture      = 1'b0;
    stallreq_o   = 1'b0;
    res_valid_o  = 1'b0;
    mul_start_o  = 1'b0;
    mul_signed_o = 1'b0;
    mul_annul_o  = 1'b0;
    mul_op1_o    = '0;
    mul_op2_o    = '0;
    div_start_o  = 1'b0;
    div_signed_o = 1'b0;
    div_annul_o  = 1'b0;
    div_op1_o    = '0;
    div_op2_o    = '0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if ((op_i != '0) && !flush_i) begin
            accept     = 1'b1;
            stallreq_o = 1'b1;
            state_d    = req_div ? DIV : MUL;
          end
        end
        MUL: begin
          mul_signed_o = sgn_q;
          mul_op1_o    = op1_q;
          mul_op2_o    = op2_q;
          if (flush_i) begin
            mul_annul_o = 1'b1;
            state_d     = IDLE;
          end else begin
            mul_start_o = 1'b1;
            stallreq_o  = 1'b1;
            if (mul_ready_i) begin
              capture = 1'b1;
              state_d = DONE;
            end
          end
        end
        DIV: begin
          div_signed_o = sgn_q;
          div_op1_o    = op1_q;
          div_op2_o    = op2_q;
          if (flush_i) begin
            div_annul_o = 1'b1;
            state_d     = IDLE;
          end else begin
            div_start_o = 1'b1;
            stallreq_o  = 1'b1;
            if (div_ready_i) begin
              capture = 1'b1;
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (flush_i) begin
            state_d = IDLE;
          end else begin
            res_valid_o = 1'b1;
            if (!ex_hold_i) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Operand latch, saturating busy counter and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      op1_q <= '0;
      op2_q <= '0;
      sgn_q <= 1'b0;
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      if (accept) begin
        op1_q <= src1_i;
        op2_q <= src2_i;
        sgn_q <= req_sgn;
        cnt_q <= '0;
      end else if ((state_q == MUL) || (state_q == DIV)) begin
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      end
      if (capture) begin
        hi_q <= result[2*W-1:W];
        lo_q <= result[W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: table-driven and randomized checks of muldiv_ctrl; the bench
// plays the mymul/div units and predicts results with plain arithmetic.
`timescale 1ns/1ps
module tb_muldiv_ctrl;

  localparam int unsigned CNT_W   = 6;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       op_i;
  logic [31:0]      src1_i, src2_i;
  logic             ex_hold_i, flush_i;
  logic             stallreq_o, res_valid_o;
  logic [31:0]      hi_o, lo_o;
  logic             mul_start_o, mul_signed_o, mul_annul_o;
  logic [31:0]      mul_op1_o, mul_op2_o;
  logic             mul_ready_i;
  logic [63:0]      mul_result_i;
  logic             div_start_o, div_signed_o, div_annul_o;
  logic [31:0]      div_op1_o, div_op2_o;
  logic             div_ready_i;
  logic [63:0]      div_result_i;
  logic [CNT_W-1:0] busy_cnt_o;

  muldiv_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .op_i(op_i), .src1_i(src1_i), .src2_i(src2_i),
    .ex_hold_i(ex_hold_i), .flush_i(flush_i), .stallreq_o(stallreq_o),
    .hi_o(hi_o), .lo_o(lo_o), .res_valid_o(res_valid_o),
    .mul_start_o(mul_start_o), .mul_signed_o(mul_signed_o), .mul_annul_o(mul_annul_o),
    .mul_op1_o(mul_op1_o), .mul_op2_o(mul_op2_o), .mul_ready_i(mul_ready_i),
    .mul_result_i(mul_result_i),
    .div_start_o(div_start_o), .div_signed_o(div_signed_o), .div_annul_o(div_annul_o),
    .div_op1_o(div_op1_o), .div_op2_o(div_op2_o), .div_ready_i(div_ready_i),
    .div_result_i(div_result_i), .busy_cnt_o(busy_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    int          hold;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        sgn;
    logic        is_div;
  } vec_t;

  vec_t        vecs[9];
  int          n_pass, n_total;
  logic [31:0] last_hi, last_lo;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Request meaning straight from the opcode table
  function automatic void decode(input logic [3:0] op, output logic is_div, output logic sgn);
    if (op[0])      begin is_div = 1'b1; sgn = 1'b1; end
    else if (op[1]) begin is_div = 1'b1; sgn = 1'b0; end
    else if (op[2]) begin is_div = 1'b0; sgn = 1'b1; end
    else            begin is_div = 1'b0; sgn = 1'b0; end
  endfunction

  // Arithmetic unit behaviour: {hi,lo} = product, or {remainder,quotient}
  function automatic logic [63:0] calc(input logic is_div, input logic sgn,
                                       input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int     ia, ib;
    if (!is_div) begin
      if (sgn) begin ia = a; ib = b; sa = ia; sb = ib; end
      else begin sa = {32'h0, a}; sb = {32'h0, b}; end
      return 64'(sa * sb);
    end
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      ia = a; ib = b;
      return {32'(ia % ib), 32'(ia / ib)};
    end
    return {a % b, a / b};
  endfunction

  // One full request: IDLE cycle, lat busy cycles, hold+1 DONE cycles
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int hold, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_sgn, input logic exp_div);
    int stall_hi, start_hi, oth_hi, sgn_bad, annul_hi, early_v, valid_cnt, done_bad, data_bad;
    stall_hi = 0; start_hi = 0; oth_hi = 0; sgn_bad = 0; annul_hi = 0;
    early_v = 0; valid_cnt = 0; done_bad = 0; data_bad = 0;
    op_i = op; src1_i = a; src2_i = b; flush_i = 1'b0; ex_hold_i = 1'b1;
    mul_ready_i = 1'b0; div_ready_i = 1'b0;
    @(negedge clk);
    if (stallreq_o) stall_hi++;
    if (mul_start_o | div_start_o) oth_hi++;
    if (res_valid_o) early_v++;
    @(posedge clk); #1;
    src1_i = $urandom; src2_i = $urandom;
    for (int n = 1; n <= lat; n++) begin
      if (exp_div) begin mul_ready_i = 1'b1; mul_result_i = 64'hDEAD_BEEF_CAFE_F00D; end
      else begin div_ready_i = 1'b1; div_result_i = 64'hDEAD_BEEF_CAFE_F00D; end
      if (n == lat) begin
        if (exp_div) begin
          div_ready_i = 1'b1; div_result_i = calc(1'b1, div_signed_o, div_op1_o, div_op2_o);
        end else begin
          mul_ready_i = 1'b1; mul_result_i = calc(1'b0, mul_signed_o, mul_op1_o, mul_op2_o);
        end
      end
      @(negedge clk);
      if (stallreq_o) stall_hi++;
      if (exp_div ? div_start_o : mul_start_o) start_hi++;
      if (exp_div ? mul_start_o : div_start_o) oth_hi++;
      if ((exp_div ? div_signed_o : mul_signed_o) !== exp_sgn) sgn_bad++;
      if (mul_annul_o | div_annul_o) annul_hi++;
      if (res_valid_o) early_v++;
      @(posedge clk); #1;
      mul_ready_i = 1'b0; div_ready_i = 1'b0;
    end
    for (int h = 0; h <= hold; h++) begin
      ex_hold_i = (h < hold);
      @(negedge clk);
      if (res_valid_o) valid_cnt++;
      if (stallreq_o | mul_start_o | div_start_o) done_bad++;
      if (hi_o !== exp_hi || lo_o !== exp_lo) data_bad++;
      @(posedge clk); #1;
    end
    ex_hold_i = 1'b0;
    check("stall_cycles", 64'(stall_hi), 64'(1 + lat));
    check("start_cycles", 64'(start_hi), 64'(lat));
    check("other_start", 64'(oth_hi), 64'd0);
    check("signed_flag", 64'(sgn_bad), 64'd0);
    check("no_annul", 64'(annul_hi), 64'd0);
    check("early_valid", 64'(early_v), 64'd0);
    check("valid_cycles", 64'(valid_cnt), 64'(hold + 1));
    check("done_quiet", 64'(done_bad), 64'd0);
    check("done_stable", 64'(data_bad), 64'd0);
    check("hi", hi_o, exp_hi);
    check("lo", lo_o, exp_lo);
    check("busy_cnt", busy_cnt_o, (lat > int'(CNT_MAX)) ? 64'(CNT_MAX) : 64'(lat));
    last_hi = exp_hi; last_lo = exp_lo;
  endtask

  // Abort on busy cycle 'at', optionally with the unit reporting ready the same cycle
  task automatic run_flush(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int at, input bit with_ready);
    logic is_div, sgn;
    int   bad;
    decode(op, is_div, sgn);
    bad = 0;
    op_i = op; src1_i = a; src2_i = b; flush_i = 1'b0; ex_hold_i = 1'b1;
    @(posedge clk); #1;
    for (int n = 1; n < at; n++) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    if (with_ready) begin
      if (is_div) begin div_ready_i = 1'b1; div_result_i = 64'h1111_2222_3333_4444; end
      else begin mul_ready_i = 1'b1; mul_result_i = 64'h1111_2222_3333_4444; end
    end
    @(negedge clk);
    check("flush_annul_sel", is_div ? div_annul_o : mul_annul_o, 64'd1);
    check("flush_annul_oth", is_div ? mul_annul_o : div_annul_o, 64'd0);
    check("flush_stall", stallreq_o, 64'd0);
    @(posedge clk); #1;
    flush_i = 1'b0; mul_ready_i = 1'b0; div_ready_i = 1'b0; op_i = 4'b0; ex_hold_i = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (mul_start_o | div_start_o | mul_annul_o | div_annul_o | res_valid_o | stallreq_o) bad++;
      @(posedge clk); #1;
    end
    check("flush_quiet", 64'(bad), 64'd0);
    check("flush_hi_kept", hi_o, last_hi);
    check("flush_lo_kept", lo_o, last_lo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic        r_div, r_sgn;
    logic [3:0]  r_op;
    logic [31:0] r_a, r_b;
    logic [63:0] r_exp;
    n_pass = 0; n_total = 0; last_hi = '0; last_lo = '0;
    rst = 1'b1; op_i = '0; src1_i = '0; src2_i = '0; ex_hold_i = 1'b0; flush_i = 1'b0;
    mul_ready_i = 1'b0; div_ready_i = 1'b0; mul_result_i = '0; div_result_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_stall", stallreq_o, 64'd0);
    check("rst_valid", res_valid_o, 64'd0);
    check("rst_hilo", {hi_o, lo_o}, 64'd0);
    check("rst_cnt", busy_cnt_o, 64'd0);
    check("rst_strobes", {mul_start_o, div_start_o, mul_annul_o, div_annul_o}, 64'd0);
    check("rst_opbus", {mul_op1_o | mul_op2_o, div_op1_o | div_op2_o}, 64'd0);
    @(posedge clk); #1;

    vecs[0] = '{4'b0100, 32'hFFFF_FFFE, 32'd3,        2,  0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1, 1'b0};
    vecs[1] = '{4'b0010, 32'd100,       32'd7,        33, 0, 32'd2,         32'd14,        1'b0, 1'b1};
    vecs[2] = '{4'b0100, 32'd5,         32'd6,        1,  3, 32'd0,         32'd30,        1'b1, 1'b0};
    vecs[3] = '{4'b1001, 32'hFFFF_FF9C, 32'd7,        70, 0, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b1, 1'b1};
    vecs[4] = '{4'b0100, 32'd3,         32'd4,        1,  0, 32'd0,         32'd12,        1'b1, 1'b0};
    vecs[5] = '{4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,1,  0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0};
    vecs[6] = '{4'b0001, 32'd123,       32'd0,        4,  1, 32'h0000_007B, 32'hFFFF_FFFF, 1'b1, 1'b1};
    vecs[7] = '{4'b0110, 32'hFFFF_FFF0, 32'd16,       3,  0, 32'd0,         32'h0FFF_FFFF, 1'b0, 1'b1};
    vecs[8] = '{4'b1000, 32'h8000_0000, 32'd2,        2,  0, 32'd1,         32'd0,         1'b0, 1'b0};
    for (int i = 0; i < 9; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].hold,
             vecs[i].hi, vecs[i].lo, vecs[i].sgn, vecs[i].is_div);
    op_i = '0;
    @(posedge clk); #1;

    run_flush(4'b0001, 32'd1000, 32'd9, 5, 1'b0);
    run_flush(4'b0100, 32'd7, 32'd8, 2, 1'b1);

    for (int i = 0; i < 20; i++) begin
      r_op = (i % 3 == 0) ? 4'($urandom_range(1, 15)) : 4'(1 << $urandom_range(0, 3));
      r_a  = $urandom;
      r_b  = $urandom;
      if (r_b == 32'h0) r_b = 32'd1;
      decode(r_op, r_div, r_sgn);
      r_exp = calc(r_div, r_sgn, r_a, r_b);
      run_op(r_op, r_a, r_b, $urandom_range(1, 8), $urandom_range(0, 2),
             r_exp[63:32], r_exp[31:0], r_sgn, r_div);
    end

    // Reset in the middle of a multiply: no annul, everything cleared
    op_i = 4'b1000; src1_i = 32'd9; src2_i = 32'd9; ex_hold_i = 1'b1;
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_stall", stallreq_o, 64'd0);
    check("midrst_annul", {mul_annul_o, div_annul_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; op_i = '0; ex_hold_i = 1'b0;
    @(negedge clk);
    check("midrst_hilo", {hi_o, lo_o}, 64'd0);
    check("midrst_cnt", busy_cnt_o, 64'd0);
    check("midrst_quiet", {res_valid_o, mul_start_o, div_start_o}, 64'd0);
    @(posedge clk); #1;
    last_hi = '0; last_lo = '0;

    run_op(4'b0010, 32'd50, 32'd8, 5, 0, 32'd2, 32'd6, 1'b0, 1'b1);
    op_i = '0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
